// File: rtl/prbs_sched_pkg.sv
// Shared types and constants for the PRBS frame scheduler.
package prbs_sched_pkg;

  // Scheduler states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_PAY  = 3'd2,
    ST_LAST = 3'd3,
    ST_GAP  = 3'd4
  } sched_state_t;

  // Smallest legal frame: one preamble, one payload and one last beat.
  localparam int MIN_FRAME_BEATS = 3;

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down-counter with enable and zero flag.
// Load wins over enable; the count saturates at zero.
module sched_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  // Count register: load takes priority, then decrement while non-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/prbs_frame_scheduler.sv
// Drives preamble/payload/last enables into the MAC PRBS generator as a
// train of frames with programmable length, gap and count, paced by
// txaxistready.
module prbs_frame_scheduler
  import prbs_sched_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             txclk,
  input  logic             txrst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic             txaxistready,
  output logic             preable_en,
  output logic             txen,
  output logic             tlast_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_BEATS);

  sched_state_t     state_reg, state_next;
  logic [LEN_W-1:0] len_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [CNT_W-1:0] num_reg;
  logic             stop_pend_reg;

  logic             latch_cfg, beat_load, beat_en, gap_load, gap_en;
  logic             frame_inc, run_end;
  logic             beat_zero, gap_zero;
  logic [LEN_W-1:0] beat_load_val;
  logic [GAP_W-1:0] gap_load_val;

  // Payload counter holds remaining beats after the current one, so the
  // PAY phase lasts len-2 accepted beats. Gap counter is loaded with
  // gap-1 so the GAP phase lasts max(gap,1) cycles.
  assign beat_load_val = len_reg - MIN_LEN;
  assign gap_load_val  = (gap_reg == '0) ? '0 : gap_reg - 1'b1;

  sched_down_counter #(.W(LEN_W)) u_beat_cnt (
    .clk      (txclk),
    .rst      (txrst),
    .load     (beat_load),
    .load_val (beat_load_val),
    .en       (beat_en),
    .zero     (beat_zero)
  );

  sched_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (txclk),
    .rst      (txrst),
    .load     (gap_load),
    .load_val (gap_load_val),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next = state_reg;
    latch_cfg  = 1'b0;
    beat_load  = 1'b0;
    beat_en    = 1'b0;
    gap_load   = 1'b0;
    gap_en     = 1'b0;
    frame_inc  = 1'b0;
    run_end    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          latch_cfg  = 1'b1;
          state_next = ST_PRE;
        end
      end
      ST_PRE: begin
        if (txaxistready) begin
          beat_load  = 1'b1;
          state_next = ST_PAY;
        end
      end
      ST_PAY: begin
        if (txaxistready) begin
          if (beat_zero) state_next = ST_LAST;
          else           beat_en    = 1'b1;
        end
      end
      ST_LAST: begin
        if (txaxistready) begin
          frame_inc  = 1'b1;
          gap_load   = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          if (stop_pend_reg || ((num_reg != '0) && (frame_count == num_reg))) begin
            run_end    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_PRE;
          end
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and registered enables / status outputs.
  always_ff @(posedge txclk or posedge txrst) begin
    if (txrst) begin
      state_reg  <= ST_IDLE;
      preable_en <= 1'b0;
      txen       <= 1'b0;
      tlast_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      preable_en <= (state_next == ST_PRE);
      txen       <= (state_next == ST_PAY);
      tlast_en   <= (state_next == ST_LAST);
      busy       <= (state_next != ST_IDLE);
      done       <= run_end;
    end
  end

  // Shadow configuration, captured only when a run starts.
  always_ff @(posedge txclk or posedge txrst) begin
    if (txrst) begin
      len_reg <= MIN_LEN;
      gap_reg <= '0;
      num_reg <= '0;
    end else if (latch_cfg) begin
      len_reg <= (cfg_frame_len < MIN_LEN) ? MIN_LEN : cfg_frame_len;
      gap_reg <= cfg_gap;
      num_reg <= cfg_num_frames;
    end
  end

  // Completed-frame counter; wraps naturally in continuous mode.
  always_ff @(posedge txclk or posedge txrst) begin
    if (txrst) begin
      frame_count <= '0;
    end else if (latch_cfg) begin
      frame_count <= '0;
    end else if (frame_inc) begin
      frame_count <= frame_count + 1'b1;
    end
  end

  // Sticky stop request; ignored in IDLE and cleared on return to IDLE.
  always_ff @(posedge txclk or posedge txrst) begin
    if (txrst) begin
      stop_pend_reg <= 1'b0;
    end else if (state_next == ST_IDLE) begin
      stop_pend_reg <= 1'b0;
    end else if (stop && (state_reg != ST_IDLE)) begin
      stop_pend_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs_frame_scheduler.sv
// Directed testbench for prbs_frame_scheduler.
module tb_prbs_frame_scheduler;

  logic        txclk;
  logic        txrst;
  logic        start;
  logic        stop;
  logic [15:0] cfg_frame_len;
  logic [7:0]  cfg_gap;
  logic [31:0] cfg_num_frames;
  logic        txaxistready;
  logic        preable_en;
  logic        txen;
  logic        tlast_en;
  logic        busy;
  logic        done;
  logic [31:0] frame_count;

  int checks;
  int failures;

  // Observation code: {preable_en, txen, tlast_en, busy, done}
  localparam logic [4:0] O_PRE  = 5'b10010;
  localparam logic [4:0] O_PAY  = 5'b01010;
  localparam logic [4:0] O_LAST = 5'b00110;
  localparam logic [4:0] O_GAP  = 5'b00010;
  localparam logic [4:0] O_DONE = 5'b00001;
  localparam logic [4:0] O_IDLE = 5'b00000;

  prbs_frame_scheduler #(
    .LEN_W (16),
    .GAP_W (8),
    .CNT_W (32)
  ) dut (
    .txclk          (txclk),
    .txrst          (txrst),
    .start          (start),
    .stop           (stop),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_gap        (cfg_gap),
    .cfg_num_frames (cfg_num_frames),
    .txaxistready   (txaxistready),
    .preable_en     (preable_en),
    .txen           (txen),
    .tlast_en       (tlast_en),
    .busy           (busy),
    .done           (done),
    .frame_count    (frame_count)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  function automatic logic [4:0] obs();
    return {preable_en, txen, tlast_en, busy, done};
  endfunction

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic test_reset();
    txrst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_frame_len = '0;
    cfg_gap = '0;
    cfg_num_frames = '0;
    txaxistready = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== O_IDLE) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", obs(), O_IDLE);
    end
    checks++;
    if (frame_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_frame_count got=%0d exp=0", frame_count);
    end
    txrst = 1'b0;
    tick();
    checks++;
    if (obs() !== O_IDLE) begin
      failures++;
      $display("FAIL reset_release_idle got=%b exp=%b", obs(), O_IDLE);
    end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single_frame();
    logic [4:0] exp_seq [9] = '{O_PRE, O_PAY, O_PAY, O_PAY, O_LAST, O_GAP, O_GAP, O_DONE, O_IDLE};
    cfg_frame_len = 16'd5;
    cfg_gap = 8'd2;
    cfg_num_frames = 32'd1;
    txaxistready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      start = (i == 0);
      tick();
      checks++;
      if (obs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL single_frame cyc%0d got=%b exp=%b", i, obs(), exp_seq[i]);
      end
    end
    start = 1'b0;
    checks++;
    if (frame_count !== 32'd1) begin
      failures++;
      $display("FAIL single_frame_count got=%0d exp=1", frame_count);
    end
    $display("test_single_frame done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_back_pressure();
    logic [4:0] exp_seq [10] = '{O_PRE, O_PAY, O_PAY, O_PAY, O_PAY, O_PAY, O_LAST, O_GAP, O_DONE, O_IDLE};
    int txen_cycles;
    int accepted;
    txen_cycles = 0;
    accepted = 0;
    cfg_frame_len = 16'd4;
    cfg_gap = 8'd1;
    cfg_num_frames = 32'd1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      txaxistready = !(i >= 2 && i <= 4);
      if (txen === 1'b1 && txaxistready) accepted++;
      tick();
      if (txen === 1'b1) txen_cycles++;
      checks++;
      if (obs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL back_pressure cyc%0d got=%b exp=%b", i, obs(), exp_seq[i]);
      end
    end
    start = 1'b0;
    txaxistready = 1'b1;
    checks++;
    if (txen_cycles != 5) begin
      failures++;
      $display("FAIL bp_txen_cycles got=%0d exp=5", txen_cycles);
    end
    checks++;
    if (accepted != 2) begin
      failures++;
      $display("FAIL bp_accepted_beats got=%0d exp=2", accepted);
    end
    $display("test_back_pressure done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clamp_gap0();
    logic [4:0] exp_seq [14] = '{O_PRE, O_PAY, O_LAST, O_GAP,
                                 O_PRE, O_PAY, O_LAST, O_GAP,
                                 O_PRE, O_PAY, O_LAST, O_GAP,
                                 O_DONE, O_IDLE};
    cfg_frame_len = 16'd1;
    cfg_gap = 8'd0;
    cfg_num_frames = 32'd3;
    txaxistready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      start = (i == 0);
      tick();
      checks++;
      if (obs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL clamp_gap0 cyc%0d got=%b exp=%b", i, obs(), exp_seq[i]);
      end
    end
    start = 1'b0;
    checks++;
    if (frame_count !== 32'd3) begin
      failures++;
      $display("FAIL clamp_gap0_count got=%0d exp=3", frame_count);
    end
    $display("test_clamp_gap0 done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_continuous_stop();
    logic [4:0] exp_q [$];
    for (int f = 0; f < 7; f++) begin
      exp_q.push_back(O_PRE);
      exp_q.push_back(O_PAY);
      exp_q.push_back(O_PAY);
      exp_q.push_back(O_LAST);
      exp_q.push_back(O_GAP);
    end
    exp_q.push_back(O_DONE);
    exp_q.push_back(O_IDLE);
    exp_q.push_back(O_IDLE);
    exp_q.push_back(O_IDLE);
    cfg_frame_len = 16'd4;
    cfg_gap = 8'd1;
    cfg_num_frames = 32'd0;
    txaxistready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      start = (i == 0);
      stop = (i == 32);
      tick();
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL cont_stop cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
      end
    end
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (frame_count !== 32'd7) begin
      failures++;
      $display("FAIL cont_stop_count got=%0d exp=7", frame_count);
    end
    $display("test_continuous_stop done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] pre_seq [8] = '{O_PRE, O_PAY, O_LAST, O_GAP, O_PRE, O_PAY, O_LAST, O_LAST};
    logic [4:0] post_seq [6] = '{O_PRE, O_PAY, O_LAST, O_GAP, O_DONE, O_IDLE};
    cfg_frame_len = 16'd3;
    cfg_gap = 8'd1;
    cfg_num_frames = 32'd0;
    for (int i = 0; i < 8; i++) begin
      start = (i == 0);
      txaxistready = (i != 7);
      tick();
      checks++;
      if (obs() !== pre_seq[i]) begin
        failures++;
        $display("FAIL rst_mid_run cyc%0d got=%b exp=%b", i, obs(), pre_seq[i]);
      end
    end
    start = 1'b0;
    checks++;
    if (frame_count !== 32'd1) begin
      failures++;
      $display("FAIL rst_mid_pre_count got=%0d exp=1", frame_count);
    end
    #2;
    txrst = 1'b1;
    #1;
    checks++;
    if (obs() !== O_IDLE) begin
      failures++;
      $display("FAIL rst_async_outputs got=%b exp=%b", obs(), O_IDLE);
    end
    checks++;
    if (frame_count !== 32'd0) begin
      failures++;
      $display("FAIL rst_async_count got=%0d exp=0", frame_count);
    end
    tick();
    txrst = 1'b0;
    txaxistready = 1'b1;
    cfg_num_frames = 32'd1;
    tick();
    checks++;
    if (obs() !== O_IDLE) begin
      failures++;
      $display("FAIL rst_wait_start got=%b exp=%b", obs(), O_IDLE);
    end
    for (int i = 0; i < 6; i++) begin
      start = (i == 0);
      tick();
      checks++;
      if (obs() !== post_seq[i]) begin
        failures++;
        $display("FAIL rst_clean_frame cyc%0d got=%b exp=%b", i, obs(), post_seq[i]);
      end
      if (i == 0) begin
        checks++;
        if (frame_count !== 32'd0) begin
          failures++;
          $display("FAIL rst_clean_start_count got=%0d exp=0", frame_count);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (frame_count !== 32'd1) begin
      failures++;
      $display("FAIL rst_clean_end_count got=%0d exp=1", frame_count);
    end
    $display("test_reset_mid_frame done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_ignored_controls();
    logic [4:0] run_seq [7] = '{O_PRE, O_PAY, O_PAY, O_LAST, O_GAP, O_DONE, O_IDLE};
    logic [4:0] two_seq [10] = '{O_PRE, O_PAY, O_LAST, O_GAP, O_PRE, O_PAY, O_LAST, O_GAP, O_DONE, O_IDLE};
    cfg_frame_len = 16'd4;
    cfg_gap = 8'd1;
    cfg_num_frames = 32'd1;
    txaxistready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      start = (i == 0 || i == 2);
      if (i == 1) begin
        cfg_frame_len = 16'd10;
        cfg_gap = 8'd7;
        cfg_num_frames = 32'd5;
      end
      tick();
      checks++;
      if (obs() !== run_seq[i]) begin
        failures++;
        $display("FAIL ignore_start cyc%0d got=%b exp=%b", i, obs(), run_seq[i]);
      end
    end
    start = 1'b0;
    checks++;
    if (frame_count !== 32'd1) begin
      failures++;
      $display("FAIL ignore_start_count got=%0d exp=1", frame_count);
    end
    for (int i = 0; i < 3; i++) begin
      stop = (i == 0);
      tick();
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_stop_busy cyc%0d got=%b exp=0", i, busy);
      end
    end
    stop = 1'b0;
    cfg_frame_len = 16'd3;
    cfg_gap = 8'd1;
    cfg_num_frames = 32'd2;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      tick();
      checks++;
      if (obs() !== two_seq[i]) begin
        failures++;
        $display("FAIL idle_stop_run cyc%0d got=%b exp=%b", i, obs(), two_seq[i]);
      end
    end
    start = 1'b0;
    checks++;
    if (frame_count !== 32'd2) begin
      failures++;
      $display("FAIL idle_stop_count got=%0d exp=2", frame_count);
    end
    $display("test_ignored_controls done: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_clamp_gap0();
    test_continuous_stop();
    test_reset_mid_frame();
    test_ignored_controls();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
